vram_frame_writer: RTL and testbench

Write-side engine for the multi-frame VRAM bank feeding the VGA display path. Accepts a 12-bit RGB444 pixel stream (valid/ready) or a constant fill colour and writes one full 200×150 frame, in raster order, into one of the NFRAMES single-frame VRAMs through their port A. It drives the write ports that the display top currently ties off, and lets frames be loaded or updated at run time without touching the read path.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/pix_addr_counter.sv | 42 ++++
 rtl/vram_frame_writer.sv | 134 +++++++++++++
 tb/tb_vram_frame_writer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame path: frame geometry, VRAM
// widths, the frame-writer state encoding and the write-port payload.
package vga_pkg;

    localparam int unsigned H_LEN     = 200;
    localparam int unsigned V_LEN     = 150;
    localparam int unsigned FRAME_PIX = H_LEN * V_LEN;
    localparam int unsigned NFRAMES   = 10;
    localparam int unsigned AW        = 15;
    localparam int unsigned DW        = 12;
    localparam int unsigned FIW       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FILL   = 2'd2,
        ST_FLUSH  = 2'd3
    } wr_state_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_beat_t;

    // One-hot VRAM select; indices beyond the bank decode to all-zero.
    function automatic logic [NFRAMES-1:0] frame_onehot(input logic [FIW-1:0] idx);
        logic [NFRAMES-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NFRAMES; i++) begin
            oh[i] = (32'(idx) == i);
        end
        return oh;
    endfunction

endpackage

// File: rtl/pix_addr_counter.sv
// Linear raster pixel counter with a registered terminal-count flag at the
// last pixel of a frame; wraps to zero after the terminal count.
module pix_addr_counter
    import vga_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [AW-1:0] cnt_o,
    output logic          tc_o
);

    localparam logic [AW-1:0] LAST_PIX = AW'(FRAME_PIX - 1);

    logic [AW-1:0] cnt_q, cnt_d;
    logic          tc_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_q ? '0 : cnt_q + AW'(1);
        end
    end

    // Flag is precomputed from the next count so it is a clean register output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d == LAST_PIX);
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = tc_q;

endmodule

// File: rtl/vram_frame_writer.sv
// Write-side engine for the multi-frame VRAM bank: writes one full frame in
// raster order from a pixel stream or a constant fill colour via port A.
module vram_frame_writer
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               fill,
    input  logic [FIW-1:0]     frame_idx,
    input  logic [DW-1:0]      fill_color,
    input  logic               abort,
    input  logic               s_valid,
    input  logic [DW-1:0]      s_data,
    output logic               s_ready,
    output logic [NFRAMES-1:0] wea,
    output logic [AW-1:0]      addra,
    output logic [DW-1:0]      dina,
    output logic               busy,
    output logic               done,
    output logic               err
);

    wr_state_e          state_q, state_d;
    logic [FIW-1:0]     frame_q, frame_d;
    logic [DW-1:0]      color_q, color_d;
    logic [NFRAMES-1:0] wea_q, wea_d;
    wr_beat_t           beat_q, beat_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               wr_en;
    logic               pix_clr;
    logic [DW-1:0]      wr_data;
    logic [AW-1:0]      pix;
    logic               pix_last;

    pix_addr_counter u_pix_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (pix_clr),
        .en_i  (wr_en),
        .cnt_o (pix),
        .tc_o  (pix_last)
    );

    // Next-state, job latching and write-stage staging.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        color_d = color_q;
        wea_d   = '0;
        beat_d  = beat_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        pix_clr = 1'b0;
        wr_data = s_data;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (32'(frame_idx) < NFRAMES) begin
                        frame_d = frame_idx;
                        color_d = fill_color;
                        pix_clr = 1'b1;
                        state_d = fill ? ST_FILL : ST_STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                wr_en   = s_valid;
                wr_data = s_data;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (s_valid && pix_last) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FILL: begin
                wr_en   = 1'b1;
                wr_data = color_q;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pix_last) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A beat accepted alongside abort still lands; abort only stops later ones.
        if (wr_en) begin
            wea_d  = frame_onehot(frame_q);
            beat_d = '{addr: pix, data: wr_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            color_q <= '0;
            wea_q   <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            color_q <= color_d;
            wea_q   <= wea_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Handshake and busy decode from the state register only.
    assign s_ready = (state_q == ST_STREAM);
    assign busy    = (state_q != ST_IDLE);
    assign wea     = wea_q;
    assign addra   = beat_q.addr;
    assign dina    = beat_q.data;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_vram_frame_writer.sv
// Self-checking bench for vram_frame_writer: command table, full fill,
// randomly bubbled stream, abort, start-while-busy and async reset.
module tb_vram_frame_writer;
    import vga_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               fill = 1'b0;
    logic [3:0]         frame_idx = '0;
    logic [DW-1:0]      fill_color = '0;
    logic               abort = 1'b0;
    logic               s_valid = 1'b0;
    logic [DW-1:0]      s_data = '0;
    logic               s_ready;
    logic [NFRAMES-1:0] wea;
    logic [AW-1:0]      addra;
    logic [DW-1:0]      dina;
    logic               busy;
    logic               done;
    logic               err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int                 cyc;
        logic [NFRAMES-1:0] wea;
        logic [AW-1:0]      addr;
        logic [DW-1:0]      data;
    } wr_rec_t;

    typedef struct {
        logic        fill;
        logic [3:0]  idx;
        logic [11:0] color;
        logic        exp_err;
        logic        exp_busy;
        logic        exp_sready;
    } cmd_vec_t;

    wr_rec_t wr_q[$];
    int      done_cyc[$];
    int      done_busy = 0;
    int      err_cnt = 0;

    vram_frame_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .fill       (fill),
        .frame_idx  (frame_idx),
        .fill_color (fill_color),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the VRAM port mid-cycle and log every write / pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (wea != '0) wr_q.push_back('{cyc, wea, addra, dina});
            if (done) begin
                done_cyc.push_back(cyc);
                if (busy) done_busy++;
            end
            if (err) err_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        done_cyc.delete();
        done_busy = 0;
        err_cnt   = 0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cyc.size() == 0 && n < 40000) begin
            step();
            n++;
        end
        chk(name, done_cyc.size() > 0, 1);
        repeat (3) step();
    endtask

    // Reference check of a complete frame: every address 0..FRAME_PIX-1 once, in order.
    task automatic check_frame(input string name, input int frame, input logic use_color,
                               input logic [DW-1:0] color);
        int nerr;
        int last_cyc;
        logic [NFRAMES-1:0] exp_wea;
        logic [DW-1:0]      exp_data;
        int                 a;
        nerr     = 0;
        exp_wea  = NFRAMES'(1) << frame;
        for (int k = 0; k < wr_q.size(); k++) begin
            a        = k;
            exp_data = use_color ? color : DW'(a);
            if (wr_q[k].wea != exp_wea || int'(wr_q[k].addr) != k || wr_q[k].data != exp_data) begin
                if (nerr < 3)
                    $display("FAIL %s_write[%0d]: wea=%b addr=%0d data=%h", name, k,
                             wr_q[k].wea, wr_q[k].addr, wr_q[k].data);
                nerr++;
            end
        end
        last_cyc = (wr_q.size() > 0) ? wr_q[wr_q.size()-1].cyc : -100;
        chk({name, "_write_count"}, wr_q.size(), FRAME_PIX);
        chk({name, "_bad_writes"}, nerr, 0);
        chk({name, "_done_count"}, done_cyc.size(), 1);
        chk({name, "_done_after_last"}, (done_cyc.size() > 0) ? done_cyc[0] : -1, last_cyc + 1);
        chk({name, "_busy_at_done"}, done_busy, 0);
        chk({name, "_err_count"}, err_cnt, 0);
    endtask

    cmd_vec_t vecs[6];

    initial begin
        int c0;
        int n;
        int guard;
        logic acc;

        vecs[0] = '{1'b1, 4'd10, 12'hABC, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'd15, 12'h000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 4'd9,  12'h5A5, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 4'd0,  12'h000, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 4'd0,  12'hFFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 4'd9,  12'h123, 1'b0, 1'b1, 1'b1};

        // Reset values
        repeat (3) step();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_wea", wea, 0);
        chk("rst_addra", addra, 0);
        chk("rst_dina", dina, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        repeat (2) step();

        // Command table: accept/reject, first-cycle behaviour, abort back to idle
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            start      = 1'b1;
            fill       = vecs[i].fill;
            frame_idx  = vecs[i].idx;
            fill_color = vecs[i].color;
            step();
            start = 1'b0;
            chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].exp_sready);
            step();
            chk($sformatf("vec%0d_err_one_cycle", i), err, 0);
            if (vecs[i].fill && vecs[i].exp_busy) begin
                chk($sformatf("vec%0d_first_wea", i), wea, NFRAMES'(1) << vecs[i].idx);
                chk($sformatf("vec%0d_first_dina", i), dina, vecs[i].color);
                chk($sformatf("vec%0d_first_addra", i), addra, 0);
            end else begin
                chk($sformatf("vec%0d_no_wea", i), wea, 0);
            end
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk($sformatf("vec%0d_idle_after_abort", i), busy, 0);
            repeat (3) step();
            chk($sformatf("vec%0d_no_done", i), done_cyc.size(), 0);
        end

        // Full fill of frame 3 with a second start (frame 5) issued while busy
        clear_mon();
        c0         = cyc;
        start      = 1'b1;
        fill       = 1'b1;
        frame_idx  = 4'd3;
        fill_color = 12'hF00;
        step();
        start = 1'b0;
        repeat (1000) step();
        start     = 1'b1;
        fill      = 1'b0;
        frame_idx = 4'd5;
        step();
        start = 1'b0;
        wait_done("fill_done_timeout");
        chk("fill_first_write_cycle", (wr_q.size() > 0) ? wr_q[0].cyc : -1, c0 + 2);
        check_frame("fill3", 3, 1'b1, 12'hF00);
        chk("fill_idle_after", busy, 0);

        // Stream into frame 0 with random bubbles; data tracks the pixel address
        clear_mon();
        start     = 1'b1;
        fill      = 1'b0;
        frame_idx = 4'd0;
        step();
        start = 1'b0;
        n     = 0;
        guard = 0;
        while (n < int'(FRAME_PIX) && guard < 60000) begin
            s_valid = ($urandom_range(3) != 0);
            s_data  = DW'(n);
            acc     = s_valid && s_ready;
            step();
            if (acc) n++;
            guard++;
        end
        s_valid = 1'b0;
        chk("stream_beats_accepted", n, FRAME_PIX);
        wait_done("stream_done_timeout");
        check_frame("stream0", 0, 1'b0, 12'h000);

        // Abort a fill of frame 1 while pixel 500 is being issued
        clear_mon();
        start      = 1'b1;
        fill       = 1'b1;
        frame_idx  = 4'd1;
        fill_color = 12'h0F0;
        step();
        start = 1'b0;
        repeat (500) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle_next", busy, 0);
        repeat (4) step();
        chk("abort_writes_le_501", wr_q.size() <= 501, 1);
        chk("abort_writes_ge_500", wr_q.size() >= 500, 1);
        chk("abort_no_done", done_cyc.size(), 0);
        chk("abort_wea_off", wea, 0);
        start     = 1'b1;
        fill      = 1'b0;
        frame_idx = 4'd4;
        step();
        start = 1'b0;
        chk("abort_restart_busy", busy, 1);
        chk("abort_restart_no_err", err, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();

        // Asynchronous reset in the middle of a stream job
        start     = 1'b1;
        frame_idx = 4'd7;
        step();
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 12'hABC;
        repeat (5) step();
        chk("pre_rst_wea", wea, NFRAMES'(1) << 7);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_s_ready", s_ready, 0);
        chk("async_rst_wea", wea, 0);
        chk("async_rst_addra", addra, 0);
        chk("async_rst_dina", dina, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_err", err, 0);
        step();
        rst     = 1'b0;
        s_valid = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_s_ready", s_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
